fsic_io_phase_sched: RTL and testbench

- ioclk-domain controller that consumes the coreclk phase count produced by the io_serdes phase counter.
- Qualifies the count into a lock status and frames the ioclk stream into pCLK_RATIO-cycle frames.
- Shares the serdes TX frame slot among pNUM_REQ requesters with round-robin arbitration.
- Sits between the phase counter and the serdes TX mux; the mux loads the granted source at frame_start.

---
 rtl/fsic_io_phase_sched_pkg.sv | 13 +
 rtl/fsic_rr_arbiter.sv | 25 ++
 rtl/fsic_io_phase_sched.sv | 84 ++++++++
 tb/tb_fsic_io_phase_sched.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fsic_io_phase_sched_pkg.sv
// fsic_io_phase_sched_pkg: shared state encoding, error-counter constants and parameter checks
package fsic_io_phase_sched_pkg;
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;
  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  function automatic bit is_pow2(input int v);
    return v >= 2 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/fsic_rr_arbiter.sv
// fsic_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module fsic_rr_arbiter #(
  parameter int pNUM_REQ = 3
) (
  input  logic [pNUM_REQ-1:0]         req,
  input  logic [$clog2(pNUM_REQ)-1:0] ptr,
  output logic [pNUM_REQ-1:0]         win,
  output logic [$clog2(pNUM_REQ)-1:0] win_idx
);
  localparam int RW = $clog2(pNUM_REQ);
  function automatic logic [RW-1:0] wrap(input int v);
    return RW'(v % pNUM_REQ);
  endfunction
  always_comb begin
    win = '0;
    win_idx = '0;
    for (int i = pNUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap(int'(ptr) + i)]) begin
        win = '0;
        win[wrap(int'(ptr) + i)] = 1'b1;
        win_idx = wrap(int'(ptr) + i);
      end
    end
  end
endmodule

// File: rtl/fsic_io_phase_sched.sv
// fsic_io_phase_sched: qualifies the serdes phase count into lock, frames ioclk and schedules the TX slot
module fsic_io_phase_sched
  import fsic_io_phase_sched_pkg::*;
#(
  parameter int pCLK_RATIO   = 4,
  parameter int pNUM_REQ     = 3,
  parameter int pLOCK_FRAMES = 4
) (
  input  logic                          ioclk,
  input  logic                          axis_rst_n,
  input  logic [$clog2(pCLK_RATIO)-1:0] phase_cnt_in,
  input  logic                          sched_en,
  input  logic [pNUM_REQ-1:0]           req,
  output logic [pNUM_REQ-1:0]           grant,
  output logic                          grant_valid,
  output logic                          frame_start,
  output logic                          phase_locked,
  output logic [ERR_W-1:0]              lock_err_cnt
);
  localparam int PW = $clog2(pCLK_RATIO);
  localparam int RW = $clog2(pNUM_REQ);
  if (!is_pow2(pCLK_RATIO)) begin : g_bad_ratio
    $error("pCLK_RATIO must be a power of two >= 2");
  end
  state_e              state;
  logic [PW-1:0]       exp_phase;
  logic [3:0]          good_frames;
  logic [RW-1:0]       ptr;
  logic [RW-1:0]       win_idx;
  logic [pNUM_REQ-1:0] win;
  logic                match;
  logic                last;
  logic                acq_done;
  logic                boundary;
  logic                lock_loss;
  logic                take;
  assign match        = phase_cnt_in == exp_phase;
  assign last         = phase_cnt_in == PW'(pCLK_RATIO - 1);
  assign acq_done     = state == ACQUIRE && match && last && good_frames == 4'(pLOCK_FRAMES - 1);
  assign boundary     = match && last && (state == LOCKED || acq_done);
  assign lock_loss    = state == LOCKED && !match;
  assign take         = sched_en && |req;
  assign phase_locked = state == LOCKED;
  fsic_rr_arbiter #(.pNUM_REQ(pNUM_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );
  // exp_phase wraps naturally because pCLK_RATIO is a power of two
  always_ff @(posedge ioclk) begin
    if (!axis_rst_n) begin
      state        <= UNLOCKED;
      exp_phase    <= '0;
      good_frames  <= '0;
      ptr          <= '0;
      grant        <= '0;
      grant_valid  <= 1'b0;
      frame_start  <= 1'b0;
      lock_err_cnt <= '0;
    end else begin
      exp_phase   <= phase_cnt_in + 1'b1;
      frame_start <= boundary;
      if (state == UNLOCKED && phase_cnt_in == '0) begin
        state       <= ACQUIRE;
        good_frames <= '0;
      end
      if (state == ACQUIRE && !match) state <= UNLOCKED;
      if (state == ACQUIRE && match && last) good_frames <= good_frames + 1'b1;
      if (acq_done) state <= LOCKED;
      if (lock_loss) begin
        state        <= UNLOCKED;
        grant        <= '0;
        grant_valid  <= 1'b0;
        lock_err_cnt <= lock_err_cnt == ERR_MAX ? ERR_MAX : lock_err_cnt + 1'b1;
      end
      if (boundary) begin
        grant       <= take ? win : '0;
        grant_valid <= take;
        if (take) ptr <= win_idx == RW'(pNUM_REQ - 1) ? '0 : win_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fsic_io_phase_sched.sv
// tb_fsic_io_phase_sched: table-driven scoreboard bench for the io phase scheduler
module tb_fsic_io_phase_sched;
  logic       ioclk = 1'b0;
  logic       axis_rst_n = 1'b0;
  logic [1:0] phase_cnt_in = 2'd0;
  logic       sched_en = 1'b0;
  logic [2:0] req = 3'd0;
  logic [2:0] grant;
  logic       grant_valid;
  logic       frame_start;
  logic       phase_locked;
  logic [7:0] lock_err_cnt;
  typedef struct {
    logic        rst_n;
    logic [1:0]  ph;
    logic        en;
    logic [2:0]  rq;
    logic [13:0] exp;
    int          tst;
  } vec_t;
  vec_t        tbl[$];
  logic [13:0] sb[$];
  logic [2:0]  cur_g = 3'd0;
  logic        cur_gv = 1'b0;
  logic [7:0]  cur_err = 8'd0;
  int          tst = 0;
  int          compared = 0;
  int          mismatched = 0;
  fsic_io_phase_sched #(.pCLK_RATIO(4), .pNUM_REQ(3), .pLOCK_FRAMES(4)) dut (
    .ioclk        (ioclk),
    .axis_rst_n   (axis_rst_n),
    .phase_cnt_in (phase_cnt_in),
    .sched_en     (sched_en),
    .req          (req),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .frame_start  (frame_start),
    .phase_locked (phase_locked),
    .lock_err_cnt (lock_err_cnt)
  );
  always #5 ioclk = ~ioclk;
  task automatic add(input logic rst_n, input logic [1:0] ph, input logic en, input logic [2:0] rq,
                     input logic [2:0] g, input logic gv, input logic fs, input logic pl, input logic [7:0] err);
    vec_t v;
    v.rst_n = rst_n;
    v.ph    = ph;
    v.en    = en;
    v.rq    = rq;
    v.exp   = {g, gv, fs, pl, err};
    v.tst   = tst;
    tbl.push_back(v);
  endtask
  // one locked frame: grant held for phases 0..2, new grant lands on the phase-3 edge
  task automatic frame(input logic en, input logic [2:0] rq, input logic [2:0] g, input logic gv);
    for (int p = 0; p < 3; p++) add(1'b1, 2'(p), en, rq, cur_g, cur_gv, 1'b0, 1'b1, cur_err);
    add(1'b1, 2'd3, en, rq, g, gv, 1'b1, 1'b1, cur_err);
    cur_g  = g;
    cur_gv = gv;
  endtask
  // four clean frames from UNLOCKED; lock and first grant land on the final phase-3 edge
  task automatic acquire(input logic en, input logic [2:0] rq, input logic [2:0] g, input logic gv);
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 4; p++)
        if (f == 3 && p == 3) add(1'b1, 2'd3, en, rq, g, gv, 1'b1, 1'b1, cur_err);
        else add(1'b1, 2'(p), en, rq, 3'd0, 1'b0, 1'b0, 1'b0, cur_err);
    cur_g  = g;
    cur_gv = gv;
  endtask
  task automatic loss(input logic [1:0] ph);
    cur_err = (cur_err == 8'd255) ? 8'd255 : cur_err + 8'd1;
    add(1'b1, ph, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, cur_err);
    cur_g  = 3'd0;
    cur_gv = 1'b0;
  endtask
  task automatic drive(input logic rst_n, input logic [1:0] ph, input logic en, input logic [2:0] rq);
    @(negedge ioclk);
    axis_rst_n   = rst_n;
    phase_cnt_in = ph;
    sched_en     = en;
    req          = rq;
    @(posedge ioclk);
    #1;
  endtask
  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got g=%b gv=%b fs=%b pl=%b err=%0d want g=%b gv=%b fs=%b pl=%b err=%0d", name,
               got[13:11], got[10], got[9], got[8], got[7:0], want[13:11], want[10], want[9], want[8], want[7:0]);
    end
  endtask
  function automatic logic [13:0] outs();
    return {grant, grant_valid, frame_start, phase_locked, lock_err_cnt};
  endfunction
  initial begin
    tst = 1;
    add(1'b0, 2'd0, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 2'd2, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    acquire(1'b1, 3'b111, 3'b001, 1'b1);
    tst = 2;
    frame(1'b1, 3'b111, 3'b010, 1'b1);
    frame(1'b1, 3'b111, 3'b100, 1'b1);
    frame(1'b1, 3'b111, 3'b001, 1'b1);
    tst = 3;
    frame(1'b1, 3'b000, 3'b000, 1'b0);
    frame(1'b1, 3'b100, 3'b100, 1'b1);
    frame(1'b1, 3'b011, 3'b001, 1'b1);
    tst = 4;
    add(1'b1, 2'd0, 1'b1, 3'b111, cur_g, cur_gv, 1'b0, 1'b1, cur_err);
    add(1'b1, 2'd1, 1'b1, 3'b111, cur_g, cur_gv, 1'b0, 1'b1, cur_err);
    loss(2'd3);
    // mismatch while acquiring drops back to UNLOCKED without counting
    add(1'b1, 2'd0, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 2'd1, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 2'd2, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 2'd3, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 2'd0, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 2'd2, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    acquire(1'b1, 3'b111, 3'b010, 1'b1);
    tst = 6;
    add(1'b1, 2'd0, 1'b1, 3'b111, 3'b010, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b1, 2'd1, 1'b1, 3'b111, 3'b010, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b1, 2'd2, 1'b0, 3'b111, 3'b010, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 8'd1);
    cur_g  = 3'd0;
    cur_gv = 1'b0;
    frame(1'b1, 3'b111, 3'b100, 1'b1);
    frame(1'b1, 3'b111, 3'b001, 1'b1);
    add(1'b1, 2'd0, 1'b1, 3'b111, 3'b001, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 2'd1, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    cur_g   = 3'd0;
    cur_gv  = 1'b0;
    cur_err = 8'd0;
    add(1'b1, 2'd3, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    acquire(1'b1, 3'b111, 3'b001, 1'b1);
    tst = 5;
    for (int k = 0; k < 256; k++) begin
      loss(2'd2);
      acquire(1'b0, 3'b111, 3'b000, 1'b0);
    end
    foreach (tbl[i]) begin
      sb.push_back(tbl[i].exp);
      drive(tbl[i].rst_n, tbl[i].ph, tbl[i].en, tbl[i].rq);
      check($sformatf("t%0d_vec%0d", tbl[i].tst, i), outs(), sb.pop_front());
    end
    drive(1'b1, 2'd1, 1'b1, 3'b111);
    check("sat_hold", outs(), {3'b000, 1'b0, 1'b0, 1'b0, 8'd255});
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 4; p++) drive(1'b1, 2'(p), 1'b1, 3'b111);
    check("relock_after_sat", outs(), {3'b010, 1'b1, 1'b1, 1'b1, 8'd255});
    drive(1'b1, 2'd0, 1'b1, 3'b111);
    check("frame_start_pulse", outs(), {3'b010, 1'b1, 1'b0, 1'b1, 8'd255});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
